pa_trace_buffer: RTL and testbench

- Synthesizable retire-trace capture block for the 5-stage PA-RISC pipeline, tapping the writeback stage.
- Records the PC, instruction, destination register, writeback data and decoded instruction class into a circular buffer.
- Freezes capture a programmable number of entries after a PC-match or opcode-class trigger.
- Contents are read out oldest-first over a simple request/valid port, giving on-chip debug without a bench monitor.

---
 rtl/pa_trace_pkg.sv | 50 +++++
 rtl/pa_inst_classifier.sv | 26 ++
 rtl/pa_trace_buffer.sv | 166 ++++++++++++++++
 tb/tb_pa_trace_buffer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pa_trace_pkg.sv
// Shared definitions for the PA-RISC retire-trace buffer: states, class codes,
// major opcodes and entry field widths.
package pa_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_POST   = 2'd2,
    ST_FROZEN = 2'd3
  } state_e;

  localparam int RD_W  = 5;
  localparam int CLS_W = 4;
  localparam int OP_W  = 6;

  localparam logic [CLS_W-1:0] CLS_NOP      = 4'd0;
  localparam logic [CLS_W-1:0] CLS_ARITH    = 4'd1;
  localparam logic [CLS_W-1:0] CLS_LOAD     = 4'd2;
  localparam logic [CLS_W-1:0] CLS_STORE    = 4'd3;
  localparam logic [CLS_W-1:0] CLS_LDO      = 4'd4;
  localparam logic [CLS_W-1:0] CLS_BL       = 4'd5;
  localparam logic [CLS_W-1:0] CLS_COMB     = 4'd6;
  localparam logic [CLS_W-1:0] CLS_IMMARITH = 4'd7;
  localparam logic [CLS_W-1:0] CLS_SHIFT    = 4'd8;
  localparam logic [CLS_W-1:0] CLS_UNKNOWN  = 4'd15;

  localparam logic [OP_W-1:0] OP_NOP   = 6'b000000;
  localparam logic [OP_W-1:0] OP_ARITH = 6'b000010;
  localparam logic [OP_W-1:0] OP_LDW   = 6'b010010;
  localparam logic [OP_W-1:0] OP_LDH   = 6'b010001;
  localparam logic [OP_W-1:0] OP_LDB   = 6'b010000;
  localparam logic [OP_W-1:0] OP_STW   = 6'b011010;
  localparam logic [OP_W-1:0] OP_STH   = 6'b011001;
  localparam logic [OP_W-1:0] OP_STB   = 6'b011000;
  localparam logic [OP_W-1:0] OP_LDO   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LDIL  = 6'b001000;
  localparam logic [OP_W-1:0] OP_BL    = 6'b111010;
  localparam logic [OP_W-1:0] OP_COMBT = 6'b100000;
  localparam logic [OP_W-1:0] OP_COMBF = 6'b100010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b101101;
  localparam logic [OP_W-1:0] OP_SUBI  = 6'b100101;
  localparam logic [OP_W-1:0] OP_SHD   = 6'b110100;
  localparam logic [OP_W-1:0] OP_EXTR  = 6'b110101;

  // Classes that retire without a register write but are still worth tracing.
  function automatic logic cls_no_rf_write(input logic [CLS_W-1:0] cls);
    return (cls == CLS_STORE) || (cls == CLS_BL) || (cls == CLS_COMB);
  endfunction

endpackage

// File: rtl/pa_inst_classifier.sv
// Combinational major-opcode to instruction-class decoder for trace records.
module pa_inst_classifier
  import pa_trace_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  output logic [CLS_W-1:0] cls
);

  // Map major opcode to trace class.
  always_comb begin
    cls = CLS_UNKNOWN;
    case (op)
      OP_NOP:                    cls = CLS_NOP;
      OP_ARITH:                  cls = CLS_ARITH;
      OP_LDW, OP_LDH, OP_LDB:    cls = CLS_LOAD;
      OP_STW, OP_STH, OP_STB:    cls = CLS_STORE;
      OP_LDO, OP_LDIL:           cls = CLS_LDO;
      OP_BL:                     cls = CLS_BL;
      OP_COMBT, OP_COMBF:        cls = CLS_COMB;
      OP_ADDI, OP_SUBI:          cls = CLS_IMMARITH;
      OP_SHD, OP_EXTR:           cls = CLS_SHIFT;
      default:                   cls = CLS_UNKNOWN;
    endcase
  end

endmodule

// File: rtl/pa_trace_buffer.sv
// Writeback-stage retire trace capture with trigger/freeze and oldest-first readout.
// Optional macro PA_TRACE_RFLE_FILTER_EN drops non-writing slots (except store/BL/COMB).
module pa_trace_buffer
  import pa_trace_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int POST_TRIG = 8,
  parameter int DW        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tr_valid,
  input  logic [DW-1:0]    tr_pc,
  input  logic [DW-1:0]    tr_inst,
  input  logic [RD_W-1:0]  tr_rd,
  input  logic [DW-1:0]    tr_pd,
  input  logic             tr_rf_le,
  input  logic             arm,
  input  logic             trig_pc_en,
  input  logic [DW-1:0]    trig_pc,
  input  logic             trig_cls_en,
  input  logic [CLS_W-1:0] trig_cls,
  input  logic             rd_en,
  output logic             rd_valid,
  output logic [DW-1:0]    rd_pc,
  output logic [DW-1:0]    rd_inst,
  output logic [DW-1:0]    rd_pd,
  output logic [RD_W-1:0]  rd_rd,
  output logic [CLS_W-1:0] rd_cls,
  output logic [AW:0]      count,
  output logic [1:0]       state,
  output logic             frozen
);

  localparam int EW   = 3*DW + RD_W + CLS_W;
  localparam int PLIM = (POST_TRIG > DEPTH) ? DEPTH : ((POST_TRIG < 1) ? 1 : POST_TRIG);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] PLIM_C  = (AW+1)'(PLIM);

  state_e            state_r, state_n;
  logic [AW-1:0]     wptr_r, wptr_n, rptr_r, rptr_n;
  logic [AW:0]       count_r, count_n, post_r, post_n;
  logic              frozen_r, wr_s, rd_s, qual_s, trig_s;
  logic [CLS_W-1:0]  cls_s;
  logic [EW-1:0]     mem_r [DEPTH];
  logic [EW-1:0]     rent_s;

  pa_inst_classifier u_cls (
    .op  (tr_inst[DW-1 -: OP_W]),
    .cls (cls_s)
  );

`ifdef PA_TRACE_RFLE_FILTER_EN
  assign qual_s = tr_valid && (tr_rf_le || cls_no_rf_write(cls_s));
`else
  logic unused_rf_le_s;
  assign unused_rf_le_s = tr_rf_le;
  assign qual_s = tr_valid;
`endif

  assign trig_s = (trig_pc_en && (tr_pc == trig_pc)) || (trig_cls_en && (cls_s == trig_cls));
  assign rent_s = mem_r[rptr_r];

  // Next-state, pointer and counter logic; arm overrides everything else.
  always_comb begin
    state_n = state_r;
    wptr_n  = wptr_r;
    rptr_n  = rptr_r;
    count_n = count_r;
    post_n  = post_r;
    wr_s    = 1'b0;
    rd_s    = 1'b0;
    if (arm) begin
      state_n = ST_ARMED;
      wptr_n  = '0;
      rptr_n  = '0;
      count_n = '0;
      post_n  = '0;
    end else begin
      case (state_r)
        ST_IDLE: state_n = ST_IDLE;
        ST_ARMED, ST_POST: begin
          if (qual_s) begin
            wr_s    = 1'b1;
            wptr_n  = wptr_r + AW'(1);
            count_n = (count_r == DEPTH_C) ? count_r : count_r + (AW+1)'(1);
            if (state_r == ST_ARMED) begin
              if (trig_s) begin
                post_n  = (AW+1)'(1);
                state_n = (PLIM_C == (AW+1)'(1)) ? ST_FROZEN : ST_POST;
              end else begin
                state_n = ST_ARMED;
              end
            end else begin
              post_n  = post_r + (AW+1)'(1);
              state_n = (post_n == PLIM_C) ? ST_FROZEN : ST_POST;
            end
            // A full buffer truncates count to 0, which still points at the oldest entry.
            rptr_n = (state_n == ST_FROZEN) ? (wptr_n - count_n[AW-1:0]) : rptr_r;
          end else begin
            state_n = state_r;
          end
        end
        ST_FROZEN: begin
          if (rd_en && (count_r != '0)) begin
            rd_s    = 1'b1;
            rptr_n  = rptr_r + AW'(1);
            count_n = count_r - (AW+1)'(1);
          end else begin
            rd_s = 1'b0;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      wptr_r   <= '0;
      rptr_r   <= '0;
      count_r  <= '0;
      post_r   <= '0;
      frozen_r <= 1'b0;
    end else begin
      state_r  <= state_n;
      wptr_r   <= wptr_n;
      rptr_r   <= rptr_n;
      count_r  <= count_n;
      post_r   <= post_n;
      frozen_r <= (state_n == ST_FROZEN);
    end
  end

  // Readout registers; data holds when no entry is delivered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_pc    <= '0;
      rd_inst  <= '0;
      rd_pd    <= '0;
      rd_rd    <= '0;
      rd_cls   <= '0;
    end else if (rd_s) begin
      rd_valid <= 1'b1;
      {rd_pc, rd_inst, rd_pd, rd_rd, rd_cls} <= rent_s;
    end else begin
      rd_valid <= 1'b0;
    end
  end

  // Trace storage.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wptr_r] <= {tr_pc, tr_inst, tr_pd, tr_rd, cls_s};
    end
  end

  assign state  = state_r;
  assign count  = count_r;
  assign frozen = frozen_r;

endmodule

// File: tb/tb_pa_trace_buffer.sv
// Directed table-driven bench for pa_trace_buffer (DEPTH=16, POST_TRIG=8).
module tb_pa_trace_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        tr_valid, tr_rf_le, arm, trig_pc_en, trig_cls_en, rd_en;
  logic [31:0] tr_pc, tr_inst, tr_pd, trig_pc;
  logic [4:0]  tr_rd;
  logic [3:0]  trig_cls;
  logic        rd_valid, frozen;
  logic [31:0] rd_pc, rd_inst, rd_pd;
  logic [4:0]  rd_rd;
  logic [3:0]  rd_cls;
  logic [4:0]  count;
  logic [1:0]  state;

  localparam logic [31:0] I_NOP = 32'h0000_0000;
  localparam logic [31:0] I_ADD = 32'h0800_0000;
  localparam logic [31:0] I_LDW = 32'h4800_0000;
  localparam logic [31:0] I_BL  = 32'hE800_0000;
  localparam logic [31:0] I_STW = 32'h6800_0000;

  always #5 clk = ~clk;

  pa_trace_buffer #(.DEPTH(16), .AW(4), .POST_TRIG(8), .DW(32)) dut (
    .clk(clk), .reset(reset), .tr_valid(tr_valid), .tr_pc(tr_pc), .tr_inst(tr_inst),
    .tr_rd(tr_rd), .tr_pd(tr_pd), .tr_rf_le(tr_rf_le), .arm(arm),
    .trig_pc_en(trig_pc_en), .trig_pc(trig_pc), .trig_cls_en(trig_cls_en),
    .trig_cls(trig_cls), .rd_en(rd_en), .rd_valid(rd_valid), .rd_pc(rd_pc),
    .rd_inst(rd_inst), .rd_pd(rd_pd), .rd_rd(rd_rd), .rd_cls(rd_cls),
    .count(count), .state(state), .frozen(frozen)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        arm;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        rde;
    logic [1:0]  st;
    logic [4:0]  cnt;
    logic        rv;
    logic        chk;
    logic [31:0] epc;
    logic [3:0]  ecls;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic a, input logic v, input logic [31:0] p,
                              input logic [31:0] i, input logic r, input logic [1:0] s,
                              input logic [4:0] c, input logic rv, input logic ck,
                              input logic [31:0] ep, input logic [3:0] ec);
    vec_t t;
    t.arm = a; t.vld = v; t.pc = p; t.inst = i; t.rde = r; t.st = s; t.cnt = c;
    t.rv = rv; t.chk = ck; t.epc = ep; t.ecls = ec;
    return t;
  endfunction

  // rd and pd are derived from the PC so readout checks every stored field.
  task automatic apply(input vec_t t, input string tag);
    logic [31:0] ep;
    arm = t.arm; tr_valid = t.vld; tr_pc = t.pc; tr_inst = t.inst; rd_en = t.rde;
    tr_rd = t.pc[6:2]; tr_pd = ~t.pc;
    @(posedge clk);
    #1;
    chk({tag, ".state"}, 32'(state), 32'(t.st));
    chk({tag, ".count"}, 32'(count), 32'(t.cnt));
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(t.rv));
    chk({tag, ".frozen"}, 32'(frozen), 32'(t.st == 2'd3));
    if (t.chk) begin
      ep = t.epc;
      chk({tag, ".rd_pc"}, rd_pc, ep);
      chk({tag, ".rd_cls"}, 32'(rd_cls), 32'(t.ecls));
      chk({tag, ".rd_pd"}, rd_pd, ~ep);
      chk({tag, ".rd_rd"}, 32'(rd_rd), 32'(ep[6:2]));
    end
  endtask

  task automatic run_tbl(input string tag);
    foreach (tbl[k]) apply(tbl[k], $sformatf("%s[%0d]", tag, k));
    tbl.delete();
    arm = 1'b0; tr_valid = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tr_valid = 1'b0; tr_rf_le = 1'b1; arm = 1'b0; trig_pc_en = 1'b0;
    trig_cls_en = 1'b0; rd_en = 1'b0; tr_pc = 32'd0; tr_inst = 32'd0; tr_pd = 32'd0;
    tr_rd = 5'd0; trig_pc = 32'd0; trig_cls = 4'd0;
    #12;
    chk("reset.state", 32'(state), 32'd0);
    chk("reset.count", 32'(count), 32'd0);
    chk("reset.rd_valid", 32'(rd_valid), 32'd0);
    chk("reset.frozen", 32'(frozen), 32'd0);
    chk("reset.rd_pc", rd_pc, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // IDLE ignores samples; then 5 untriggered samples; rd_en outside FROZEN does nothing.
    tbl.push_back(mk(1'b0, 1'b1, 32'd0, I_ADD, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 32'd0, 4'd0));
    tbl.push_back(mk(1'b1, 1'b0, 32'd0, I_NOP, 1'b0, 2'd1, 5'd0, 1'b0, 1'b0, 32'd0, 4'd0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1'b0, 1'b1, 32'(4*i), I_ADD, 1'b0, 2'd1, 5'(i+1), 1'b0, 1'b0, 32'd0, 4'd0));
    tbl.push_back(mk(1'b0, 1'b0, 32'd0, I_NOP, 1'b1, 2'd1, 5'd5, 1'b0, 1'b0, 32'd0, 4'd0));
    run_tbl("armed");

    // PC trigger at 40: wrap, freeze after PC=68, read 8..68 oldest-first.
    trig_pc_en = 1'b1; trig_pc = 32'd40; trig_cls_en = 1'b0;
    tbl.push_back(mk(1'b1, 1'b0, 32'd0, I_NOP, 1'b0, 2'd1, 5'd0, 1'b0, 1'b0, 32'd0, 4'd0));
    for (int i = 0; i < 20; i++) begin
      logic [1:0] s;
      logic [4:0] c;
      if (i < 10) begin
        s = 2'd1; c = 5'(i+1);
      end else if (i < 17) begin
        s = 2'd2; c = (i + 1 > 16) ? 5'd16 : 5'(i+1);
      end else begin
        s = 2'd3; c = 5'd16;
      end
      tbl.push_back(mk(1'b0, 1'b1, 32'(4*i), I_ADD, 1'b0, s, c, 1'b0, 1'b0, 32'd0, 4'd0));
    end
    for (int k = 0; k < 16; k++) begin
      tbl.push_back(mk(1'b0, 1'b0, 32'd0, I_NOP, 1'b1, 2'd3, 5'(15-k), 1'b1, 1'b1, 32'(8+4*k), 4'd1));
      if (k == 3)
        tbl.push_back(mk(1'b0, 1'b0, 32'd0, I_NOP, 1'b0, 2'd3, 5'd12, 1'b0, 1'b1, 32'd20, 4'd1));
    end
    tbl.push_back(mk(1'b0, 1'b0, 32'd0, I_NOP, 1'b1, 2'd3, 5'd0, 1'b0, 1'b1, 32'd68, 4'd1));
    run_tbl("pctrig");

    // Class trigger on BL (class 5); ADD/LDW precede it.
    trig_pc_en = 1'b0; trig_cls_en = 1'b1; trig_cls = 4'd5;
    tbl.push_back(mk(1'b1, 1'b0, 32'd0, I_NOP, 1'b0, 2'd1, 5'd0, 1'b0, 1'b0, 32'd0, 4'd0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h100, I_ADD, 1'b0, 2'd1, 5'd1, 1'b0, 1'b0, 32'd0, 4'd0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h104, I_LDW, 1'b0, 2'd1, 5'd2, 1'b0, 1'b0, 32'd0, 4'd0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h108, I_BL, 1'b0, 2'd2, 5'd3, 1'b0, 1'b0, 32'd0, 4'd0));
    for (int i = 0; i < 7; i++)
      tbl.push_back(mk(1'b0, 1'b1, 32'(32'h10C + 4*i), I_NOP, 1'b0, (i == 6) ? 2'd3 : 2'd2,
                       5'(4+i), 1'b0, 1'b0, 32'd0, 4'd0));
    tbl.push_back(mk(1'b0, 1'b0, 32'd0, I_NOP, 1'b1, 2'd3, 5'd9, 1'b1, 1'b1, 32'h100, 4'd1));
    tbl.push_back(mk(1'b0, 1'b0, 32'd0, I_NOP, 1'b1, 2'd3, 5'd8, 1'b1, 1'b1, 32'h104, 4'd2));
    tbl.push_back(mk(1'b0, 1'b0, 32'd0, I_NOP, 1'b1, 2'd3, 5'd7, 1'b1, 1'b1, 32'h108, 4'd5));
    run_tbl("clstrig");
    chk("clstrig.rd_inst", rd_inst, I_BL);

    // arm coincident with a trigger-matching sample: discarded, still ARMED.
    trig_cls_en = 1'b0; trig_pc_en = 1'b1; trig_pc = 32'h200;
    tbl.push_back(mk(1'b1, 1'b0, 32'd0, I_NOP, 1'b0, 2'd1, 5'd0, 1'b0, 1'b0, 32'd0, 4'd0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h300, I_ADD, 1'b0, 2'd1, 5'd1, 1'b0, 1'b0, 32'd0, 4'd0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h304, I_ADD, 1'b0, 2'd1, 5'd2, 1'b0, 1'b0, 32'd0, 4'd0));
    tbl.push_back(mk(1'b1, 1'b1, 32'h200, I_ADD, 1'b0, 2'd1, 5'd0, 1'b0, 1'b0, 32'd0, 4'd0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h308, I_ADD, 1'b0, 2'd1, 5'd1, 1'b0, 1'b0, 32'd0, 4'd0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h200, I_ADD, 1'b0, 2'd2, 5'd2, 1'b0, 1'b0, 32'd0, 4'd0));
    run_tbl("armwin");

    // Reach POST with count=10, then asynchronous reset between edges.
    trig_pc = 32'h14;
    tbl.push_back(mk(1'b1, 1'b0, 32'd0, I_NOP, 1'b0, 2'd1, 5'd0, 1'b0, 1'b0, 32'd0, 4'd0));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(1'b0, 1'b1, 32'(4*i), I_ADD, 1'b0, (i < 5) ? 2'd1 : 2'd2, 5'(i+1),
                       1'b0, 1'b0, 32'd0, 4'd0));
    run_tbl("post");
    #2;
    reset = 1'b1;
    #1;
    chk("asyncrst.state", 32'(state), 32'd0);
    chk("asyncrst.count", 32'(count), 32'd0);
    chk("asyncrst.rd_valid", 32'(rd_valid), 32'd0);
    chk("asyncrst.frozen", 32'(frozen), 32'd0);
    chk("asyncrst.rd_pc", rd_pc, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("afterrst.state", 32'(state), 32'd0);

    // Non-writing slots: filtered build keeps only the store.
    trig_pc_en = 1'b0; tr_rf_le = 1'b0;
`ifdef PA_TRACE_RFLE_FILTER_EN
    tbl.push_back(mk(1'b1, 1'b0, 32'd0, I_NOP, 1'b0, 2'd1, 5'd0, 1'b0, 1'b0, 32'd0, 4'd0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h400, I_NOP, 1'b0, 2'd1, 5'd0, 1'b0, 1'b0, 32'd0, 4'd0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h404, I_ADD, 1'b0, 2'd1, 5'd0, 1'b0, 1'b0, 32'd0, 4'd0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h408, I_STW, 1'b0, 2'd1, 5'd1, 1'b0, 1'b0, 32'd0, 4'd0));
`else
    tbl.push_back(mk(1'b1, 1'b0, 32'd0, I_NOP, 1'b0, 2'd1, 5'd0, 1'b0, 1'b0, 32'd0, 4'd0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h400, I_NOP, 1'b0, 2'd1, 5'd1, 1'b0, 1'b0, 32'd0, 4'd0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h404, I_ADD, 1'b0, 2'd1, 5'd2, 1'b0, 1'b0, 32'd0, 4'd0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h408, I_STW, 1'b0, 2'd1, 5'd3, 1'b0, 1'b0, 32'd0, 4'd0));
`endif
    run_tbl("rfle");
    tr_rf_le = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
